// File: rtl/spi_fl_seq_if.sv
// Request/response and SPI-master command bus of the flash sequencer.
// slave = the sequencer itself; master = CPU register file plus SPI master side.
`timescale 1ns/1ps
interface spi_fl_seq_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        m_validflag;
  logic [2:0]  m_commtype;
  logic [7:0]  m_command;
  logic [23:0] m_address;
  logic [31:0] m_data_in;
  logic [6:0]  m_nmiso_bits;
  logic        m_tready;
  logic        m_validflag_out;
  logic [31:0] m_data_out;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  m_tready, m_validflag_out, m_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_validflag, m_commtype, m_command, m_address, m_data_in, m_nmiso_bits
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output m_tready, m_validflag_out, m_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_validflag, m_commtype, m_command, m_address, m_data_in, m_nmiso_bits
  );
endinterface

// File: rtl/spi_fl_seq.sv
// Expands word-level flash requests into WREN / op / RDSR-poll SPI transactions.
// One request in flight; response one cycle after the last transaction completes.
`timescale 1ns/1ps
module spi_fl_seq #(
  parameter logic [15:0] POLL_MAX = 16'd1000,
  parameter int          POLL_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  spi_fl_seq_if.slave  bus
);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX - 16'd1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_NEXT, S_RESP} state_t;
  typedef enum logic [2:0] {T_RD, T_WREN, T_PP, T_SE, T_RDSR} txn_t;

  state_t state, state_nxt;
  txn_t   cur, load_txn;

  logic [1:0]        op_q;
  logic [23:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [POLL_W-1:0] poll_cnt;
  logic [31:0]       cap;
  logic              got_ans, vo_q;
  logic [7:0]        cmd_q;
  logic [2:0]        ct_q;
  logic [23:0]       maddr_q;
  logic [31:0]       mdata_q;
  logic [6:0]        nmiso_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept, vo_rise, want_ans, ans_ok;
  logic              load_en, poll_inc, poll_fail;
  logic [23:0]       addr_src;

  assign accept   = (state == S_IDLE) && bus.req_valid;
  assign vo_rise  = bus.m_validflag_out && !vo_q;
  assign want_ans = (cur == T_RD) || (cur == T_RDSR);
  // An answer arriving together with tready completes the transaction at once.
  assign ans_ok   = !want_ans || got_ans || vo_rise;
  assign addr_src = accept ? bus.req_addr : addr_q;

  assign bus.m_command    = cmd_q;
  assign bus.m_commtype   = ct_q;
  assign bus.m_address    = maddr_q;
  assign bus.m_data_in    = mdata_q;
  assign bus.m_nmiso_bits = nmiso_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;

  // Which transaction (if any) to load next: first one on accept, successor in NEXT.
  always_comb begin
    load_en   = 1'b0;
    load_txn  = T_RD;
    poll_inc  = 1'b0;
    poll_fail = 1'b0;
    if (accept) begin
      load_en = 1'b1;
      case (bus.req_op)
        2'b00:   load_txn = T_RD;
        2'b11:   load_txn = T_RDSR;
        default: load_txn = T_WREN;
      endcase
    end else if (state == S_NEXT) begin
      case (cur)
        T_WREN: begin
          load_en  = 1'b1;
          load_txn = (op_q == 2'b01) ? T_PP : T_SE;
        end
        T_PP, T_SE: begin
          load_en  = 1'b1;
          load_txn = T_RDSR;
        end
        T_RDSR: begin
          if (op_q != 2'b11 && cap[24]) begin
            if (poll_cnt < POLL_LIM) begin
              load_en  = 1'b1;
              load_txn = T_RDSR;
              poll_inc = 1'b1;
            end else begin
              poll_fail = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (!bus.m_tready) state_nxt = S_BUSY;
      S_BUSY:  if (bus.m_tready && ans_ok) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = load_en ? S_ISSUE : S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state == S_IDLE);
    bus.m_validflag = (state == S_ISSUE);
    bus.resp_valid  = (state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= T_RD;
      op_q     <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      poll_cnt <= '0;
      cap      <= '0;
      got_ans  <= 1'b0;
      vo_q     <= 1'b0;
      cmd_q    <= '0;
      ct_q     <= 3'b111;
      maddr_q  <= '0;
      mdata_q  <= '0;
      nmiso_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      vo_q <= bus.m_validflag_out;
      if (accept) begin
        op_q     <= bus.req_op;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        poll_cnt <= '0;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end
      if (poll_inc) poll_cnt <= poll_cnt + POLL_W'(1);
      if (load_en) begin
        cur     <= load_txn;
        got_ans <= 1'b0;
        maddr_q <= '0;
        mdata_q <= '0;
        case (load_txn)
          T_RD:    begin cmd_q <= 8'h03; ct_q <= 3'b010; nmiso_q <= 7'd32; maddr_q <= addr_src; end
          T_WREN:  begin cmd_q <= 8'h06; ct_q <= 3'b000; nmiso_q <= 7'd0; end
          T_PP:    begin cmd_q <= 8'h02; ct_q <= 3'b100; nmiso_q <= 7'd0; maddr_q <= addr_src; mdata_q <= wdata_q; end
          T_SE:    begin cmd_q <= 8'hD8; ct_q <= 3'b101; nmiso_q <= 7'd0; maddr_q <= addr_src; end
          default: begin cmd_q <= 8'h05; ct_q <= 3'b001; nmiso_q <= 7'd8; end
        endcase
      end else if (state == S_BUSY && vo_rise && want_ans) begin
        cap     <= bus.m_data_out;
        got_ans <= 1'b1;
      end
      if (state == S_NEXT && !load_en) begin
        err_q <= poll_fail;
        case (op_q)
          2'b00:   rdata_q <= cap;
          2'b11:   rdata_q <= {24'b0, cap[31:24]};
          default: rdata_q <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_fl_seq.sv
// Directed bench for spi_fl_seq with a behavioural SPI master and a response scoreboard.
`timescale 1ns/1ps
module tb_spi_fl_seq;
  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [23:0] addr;
    logic [31:0] data;
    logic [6:0]  nmiso;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_fl_seq_if bus();
  spi_fl_seq #(.POLL_MAX(16'd4), .POLL_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_txn_q[$];
  logic [32:0] exp_resp_q[$];
  logic [31:0] ans_q[$];
  int          hold_cycles = 0;
  int          busy_len = 2;
  bit          in_busy = 1'b0;
  logic [7:0]  last_cmd = 8'h00;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic txn_t t_rd(input logic [23:0] a);
    return '{8'h03, 3'b010, a, 32'h0, 7'd32};
  endfunction
  function automatic txn_t t_wren();
    return '{8'h06, 3'b000, 24'h0, 32'h0, 7'd0};
  endfunction
  function automatic txn_t t_pp(input logic [23:0] a, input logic [31:0] d);
    return '{8'h02, 3'b100, a, d, 7'd0};
  endfunction
  function automatic txn_t t_se(input logic [23:0] a);
    return '{8'hD8, 3'b101, a, 32'h0, 7'd0};
  endfunction
  function automatic txn_t t_rdsr();
    return '{8'h05, 3'b001, 24'h0, 32'h0, 7'd8};
  endfunction

  function automatic txn_t cur_txn();
    return '{bus.m_command, bus.m_commtype, bus.m_address, bus.m_data_in, bus.m_nmiso_bits};
  endfunction

  // SPI master model: checks each issued command, holds tready, then answers.
  initial begin : master_model
    txn_t got, snap;
    bit early;
    logic [31:0] a;
    early = 1'b0;
    bus.m_tready = 1'b1;
    bus.m_validflag_out = 1'b0;
    bus.m_data_out = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_validflag) begin
        got = cur_txn();
        last_cmd = got.cmd;
        if (exp_txn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL txn_unexpected: got %0h, required no transaction", got);
        end else begin
          chk("txn_fields", 80'(got), 80'(exp_txn_q.pop_front()));
        end
        snap = got;
        for (int i = 0; i < hold_cycles; i++) begin
          @(negedge clk);
          chk("vf_hold", 80'({bus.m_validflag, cur_txn()}), 80'({1'b1, snap}));
        end
        bus.m_tready = 1'b0;
        @(negedge clk);
        chk("vf_drop", 80'(bus.m_validflag), 80'd0);
        in_busy = 1'b1;
        for (int i = 0; i < busy_len && !rst; i++) @(negedge clk);
        if (!rst && got.nmiso != 7'd0) begin
          if (ans_q.size() != 0) a = ans_q.pop_front();
          else a = 32'h0;
          bus.m_data_out = a;
          bus.m_validflag_out = 1'b1;
          if (early) begin
            @(negedge clk);
            bus.m_validflag_out = 1'b0;
          end
          early = ~early;
        end
        bus.m_tready = 1'b1;
        in_busy = 1'b0;
        @(negedge clk);
        bus.m_validflag_out = 1'b0;
      end
    end
  end

  initial begin : resp_monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got rdata %h err %b, required no response", bus.resp_rdata, bus.resp_err);
        end else begin
          e = exp_resp_q.pop_front();
          chk("resp_data_err", 80'({bus.resp_rdata, bus.resp_err}), 80'(e));
        end
      end
    end
  end

  task automatic run(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d, input bit stray);
    int n;
    chk("ready_before_req", 80'(bus.req_ready), 80'd1);
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = stray;
    if (stray) begin
      bus.req_op = 2'b11;
      bus.req_addr = 24'hFFFFFF;
    end
    chk("issue_latency", 80'(bus.m_validflag), 80'd1);
    chk("ready_low_busy", 80'(bus.req_ready), 80'd0);
    n = 0;
    while (!bus.resp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b0;
    if (!bus.resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid in %0d cycles, required one", n);
    end
    @(negedge clk);
    chk("ready_after_resp", 80'(bus.req_ready), 80'd1);
    chk("resp_single_pulse", 80'(bus.resp_valid), 80'd0);
  endtask

  initial begin : main
    int n;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_addr = 24'h0;
    bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 80'(bus.req_ready), 80'd1);
    chk("rst_resp_valid", 80'(bus.resp_valid), 80'd0);
    chk("rst_resp_rdata_err", 80'({bus.resp_rdata, bus.resp_err}), 80'd0);
    chk("rst_m_validflag", 80'(bus.m_validflag), 80'd0);
    chk("rst_m_commtype", 80'(bus.m_commtype), 80'd7);
    chk("rst_m_fields", 80'({bus.m_command, bus.m_address, bus.m_data_in, bus.m_nmiso_bits}), 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read word; answer arrives together with tready.
    ans_q.push_back(32'hDEADBEEF);
    exp_txn_q.push_back(t_rd(24'h012345));
    exp_resp_q.push_back({32'hDEADBEEF, 1'b0});
    run(2'b00, 24'h012345, 32'h0, 1'b0);

    // Program with three status polls.
    exp_txn_q.push_back(t_wren());
    exp_txn_q.push_back(t_pp(24'h000100, 32'hA5A5A5A5));
    repeat (3) exp_txn_q.push_back(t_rdsr());
    ans_q.push_back(32'h01000000);
    ans_q.push_back(32'h01000000);
    ans_q.push_back(32'h00000000);
    exp_resp_q.push_back({32'h0, 1'b0});
    run(2'b01, 24'h000100, 32'hA5A5A5A5, 1'b0);

    // Erase where WIP never clears: four polls then error.
    exp_txn_q.push_back(t_wren());
    exp_txn_q.push_back(t_se(24'h030000));
    repeat (4) begin
      exp_txn_q.push_back(t_rdsr());
      ans_q.push_back(32'h01000000);
    end
    exp_resp_q.push_back({32'h0, 1'b1});
    run(2'b10, 24'h030000, 32'h0, 1'b0);

    // Read status.
    exp_txn_q.push_back(t_rdsr());
    ans_q.push_back(32'h5A000000);
    exp_resp_q.push_back({32'h0000005A, 1'b0});
    run(2'b11, 24'h000000, 32'h0, 1'b0);

    // Slow master plus a stray request held during the operation.
    hold_cycles = 5;
    exp_txn_q.push_back(t_rd(24'h00ABCD));
    ans_q.push_back(32'h13579BDF);
    exp_resp_q.push_back({32'h13579BDF, 1'b0});
    run(2'b00, 24'h00ABCD, 32'h0, 1'b1);
    hold_cycles = 0;

    // Reset while the page program is in flight: no response may appear.
    busy_len = 20;
    exp_txn_q.push_back(t_wren());
    exp_txn_q.push_back(t_pp(24'h000200, 32'h12345678));
    bus.req_op = 2'b01;
    bus.req_addr = 24'h000200;
    bus.req_wdata = 32'h12345678;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(in_busy && last_cmd == 8'h02) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(in_busy && last_cmd == 8'h02)) begin
      checks++;
      errors++;
      $display("FAIL pp_busy_timeout: got no PP busy phase in %0d cycles, required one", n);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_validflag", 80'(bus.m_validflag), 80'd0);
    chk("midrst_req_ready", 80'(bus.req_ready), 80'd1);
    chk("midrst_resp_valid", 80'(bus.resp_valid), 80'd0);
    chk("midrst_commtype", 80'(bus.m_commtype), 80'd7);
    @(negedge clk);
    rst = 1'b0;
    busy_len = 2;
    @(negedge clk);

    // A read after the reset completes normally.
    ans_q.push_back(32'hCAFEF00D);
    exp_txn_q.push_back(t_rd(24'hFEDCBA));
    exp_resp_q.push_back({32'hCAFEF00D, 1'b0});
    run(2'b00, 24'hFEDCBA, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    chk("resp_q_drained", 80'(exp_resp_q.size()), 80'd0);
    chk("txn_q_drained", 80'(exp_txn_q.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_fl_seq.md
# spi_fl_seq

Flash command sequencer sitting directly upstream of the SPI flash master. It accepts word-level requests from the CPU-side register file: read word, program word, sector erase and read status. It expands each request into the ordered SPI command transactions the master executes: write-enable, the operation itself, then status polling until the flash clears WIP. It returns one response per request, carrying read data or an error flag.

## Interface
Parameters:
- POLL_MAX, 16'd1000: maximum number of RDSR polls after a program or erase before the request is aborted with an error.
- POLL_W, 16: width of the poll counter.

Ports:
- Clocking and reset (already decided): one clock `clk`; `rst` is synchronous and active-high.
- clk  in  1  system clock; also the clock of the SPI master's register side.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request strobe; a request is accepted when req_valid && req_ready.
- req_op  in  2  request type: 00 read word, 01 program word, 10 sector erase, 11 read status.
- req_addr  in  24  flash byte address.
- req_wdata  in  32  program data.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  32  read data, or status for op 11; 0 otherwise.
- resp_err  out  1  poll limit exceeded; valid with resp_valid.
- m_validflag  out  1  command strobe to the master.
- m_commtype  out  3  master command type.
- m_command  out  8  SPI opcode.
- m_address  out  24  SPI address field.
- m_data_in  out  32  SPI data field.
- m_nmiso_bits  out  7  number of answer bits expected.
- m_tready  in  1  master idle.
- m_validflag_out  in  1  master answer-valid.
- m_data_out  in  32  master answer; MSB-aligned.

## Operation
Transaction table (opcode / commtype / nmiso):
- RD: 0x03 / 010 / 32.
- WREN: 0x06 / 000 / 0.
- PP: 0x02 / 100 / 0.
- SE: 0xD8 / 101 / 0.
- RDSR: 0x05 / 001 / 8.

Sequences per request:
- op 00: RD.
- op 01: WREN, PP, then RDSR poll.
- op 10: WREN, SE, then RDSR poll.
- op 11: a single RDSR.

Status byte and WIP:
- An 8-bit answer lands in m_data_out[31:24].
- WIP = m_data_out[24].

FSM states and transitions:
- IDLE: req_ready=1. On accept, register op/addr/wdata and load the first transaction; go to ISSUE.
- ISSUE: m_validflag=1; all m_* held stable. Go to BUSY on the first cycle m_tready==0.
- BUSY: m_validflag=0.
  - For commtype 001/010: capture m_data_out on the cycle a rising edge of m_validflag_out is detected (edge detector registered).
  - Go to NEXT when m_tready==1 and, if an answer is expected, the answer has been captured.
- NEXT: select the next transaction in the sequence.
  - After a poll: WIP=1 and poll_cnt<POLL_MAX-1 → increment poll_cnt and reissue RDSR; WIP=1 at the limit → RESP with err=1; WIP=0 → RESP.
  - Sequence finished → RESP.
- RESP: resp_valid=1 for one cycle; then IDLE.

Field rules:
- m_address = req_addr for RD/PP/SE; 0 otherwise.
- m_data_in = req_wdata for PP; 0 otherwise.
- resp_rdata = captured word for op 00; {24'b0, status} for op 11; 0 for ops 01/10.
- poll_cnt is cleared on accept.

## Timing
Reset values:
- req_ready=1.
- resp_valid=0, resp_rdata=0, resp_err=0.
- m_validflag=0, m_commtype=3'b111.
- m_command=0, m_address=0, m_data_in=0, m_nmiso_bits=0.
- FSM in IDLE; poll_cnt=0; edge detector cleared.

Latency and handshake:
- Acceptance to m_validflag=1: 1 cycle.
- m_validflag must never be reasserted before m_tready has returned to 1. This guarantees the master sees a fresh rising level per transaction.
- req_valid is ignored while not in IDLE; a request is never queued.
- resp_valid to the next req_ready=1: 1 cycle. Back-to-back requests are therefore at least 2 cycles apart at the CPU side.

Boundary conditions:
- If m_validflag_out rises in the same cycle m_tready rises, capture and complete in that cycle.
- A rising edge of m_validflag_out in ISSUE or IDLE is ignored.
- Reset in any state returns to IDLE next cycle with all outputs at reset values. A pending response is dropped.
- POLL_MAX=1: a single poll with WIP=1 yields err.

## Test plan
- Read word: op 00, addr 0x012345; master model returns 0xDEADBEEF → one transaction {0x03, 010, 0x012345, nmiso 32}; resp_valid with rdata 0xDEADBEEF, err 0.
- Program with polling: op 01, addr 0x000100, data 0xA5A5A5A5; status answers 0x01, 0x01, 0x00 → issues WREN, PP {0x02, 100, 0x000100, 0xA5A5A5A5}, then 3 RDSR; response rdata 0, err 0.
- Erase timeout: POLL_MAX=4, op 10; WIP stays 1 → exactly WREN, SE, 4 RDSR; resp_err=1.
- Read status: op 11; answer m_data_out=0x5A000000 → resp_rdata=0x0000005A.
- Handshake discipline: master model holds m_tready high for 5 cycles after validflag → m_validflag stays high and stable until m_tready falls, then drops. A req_valid asserted during the op is not accepted.
- Reset mid-program: assert rst during PP BUSY → next cycle m_validflag=0, req_ready=1, no resp_valid. A following read completes normally.
